// File: rtl/regfile_wr_sched_if.sv
// Two-requester write bundle for the register file write scheduler.
// Requesters hold valid/addr/data until the scheduler raises ready.
interface regfile_wr_sched_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             req0_valid;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Register file write-port scheduler: zero sweep after reset/clear,
// then round-robin sharing of the single write port.
module regfile_wr_sched #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    regfile_wr_sched_if.slave req,
    output logic              we,
    output logic [AW-1:0]     write_reg,
    output logic [WIDTH-1:0]  write_data,
    output logic              init_done
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             we_d, init_done_d;
    logic [AW-1:0]    write_reg_d;
    logic [WIDTH-1:0] write_data_d;
    logic             gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            we         <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            we         <= we_d;
            write_reg  <= write_reg_d;
            write_data <= write_data_d;
            init_done  <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        we_d         = 1'b0;
        write_reg_d  = write_reg;
        write_data_d = write_data;
        init_done_d  = init_done;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        unique case (state_q)
            INIT: begin
                we_d         = 1'b1;
                write_reg_d  = cnt_q;
                write_data_d = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d     = INIT;
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    gnt0 = req.req0_valid & (~req.req1_valid | ~ptr_q);
                    gnt1 = req.req1_valid & (~req.req0_valid | ptr_q);
                    // pointer moves only when both were competing
                    if (gnt0) begin
                        we_d         = 1'b1;
                        write_reg_d  = req.req0_addr;
                        write_data_d = req.req0_data;
                        if (req.req1_valid) ptr_d = 1'b1;
                    end else if (gnt1) begin
                        we_d         = 1'b1;
                        write_reg_d  = req.req1_addr;
                        write_data_d = req.req1_data;
                        if (req.req0_valid) ptr_d = 1'b0;
                    end
                end
            end
        endcase
    end

    assign req.req0_ready = gnt0;
    assign req.req1_ready = gnt1;
endmodule
